// File: rtl/video_timing_pkg.sv
// ----------------------------------------------------------------------------
// video_timing_pkg
//   Shared definitions for the raster source:
//     - VtgGeom : one sync/back/disp/front set for H and V
//     - preset geometries for common display modes
//     - VtgState: run-control FSM states
//   No ports (package).
// ----------------------------------------------------------------------------
package video_timing_pkg;

    typedef struct packed {
        int unsigned hSync;
        int unsigned hBack;
        int unsigned hDisp;
        int unsigned hFront;
        int unsigned vSync;
        int unsigned vBack;
        int unsigned vDisp;
        int unsigned vFront;
    } VtgGeom;

    // 1920x1080 @ 30 Hz, 74.25 MHz pixel clock
    localparam VtgGeom GEOM_1080P30 = '{hSync: 44,  hBack: 148, hDisp: 1920, hFront: 88,
                                        vSync: 5,   vBack: 36,  vDisp: 1080, vFront: 4};
    // 1280x720 @ 60 Hz, 74.25 MHz pixel clock
    localparam VtgGeom GEOM_720P60  = '{hSync: 40,  hBack: 220, hDisp: 1280, hFront: 110,
                                        vSync: 5,   vBack: 20,  vDisp: 720,  vFront: 5};
    // 1024x768 @ 60 Hz (XGA), 65 MHz pixel clock
    localparam VtgGeom GEOM_XGA     = '{hSync: 136, hBack: 160, hDisp: 1024, hFront: 24,
                                        vSync: 6,   vBack: 29,  vDisp: 768,  vFront: 3};
    // 800x600 @ 60 Hz (SVGA), 40 MHz pixel clock
    localparam VtgGeom GEOM_SVGA    = '{hSync: 128, hBack: 88,  hDisp: 800,  hFront: 40,
                                        vSync: 4,   vBack: 23,  vDisp: 600,  vFront: 1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } VtgState;

endpackage

// File: rtl/video_sync_delay.sv
// ----------------------------------------------------------------------------
// video_sync_delay
//   Shift register of configurable depth for the {DE, HS, VS} control triple,
//   used to align sync/enable with pixel data arriving from a pipelined
//   fetch. Depth 0 is a combinational pass-through.
//
// Ports
//   PixelClk   in   pixel clock
//   RstB       in   asynchronous active-low reset (stages go to idle levels)
//   DeIn/HsIn/VsIn    in   control triple, undelayed
//   DeOut/HsOut/VsOut out  control triple, DEPTH cycles later
// ----------------------------------------------------------------------------
module video_sync_delay #(
    parameter int   DEPTH   = 1,
    parameter logic HS_IDLE = 1'b0,
    parameter logic VS_IDLE = 1'b0
) (
    input  logic PixelClk,
    input  logic RstB,
    input  logic DeIn,
    input  logic HsIn,
    input  logic VsIn,
    output logic DeOut,
    output logic HsOut,
    output logic VsOut
);

    generate
        if (DEPTH == 0) begin : gPass
            assign DeOut = DeIn;
            assign HsOut = HsIn;
            assign VsOut = VsIn;
        end else begin : gShift
            localparam logic [2:0] IDLE_VEC = {1'b0, HS_IDLE, VS_IDLE};

            logic [2:0] stage [DEPTH];

            // NOTE: every stage is reset, unlike a data RAM: a stale HS/VS
            // level would leak a bogus sync pulse onto the link after reset.
            always_ff @(posedge PixelClk or negedge RstB) begin
                if (!RstB) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= IDLE_VEC;
                end else begin
                    stage[0] <= {DeIn, HsIn, VsIn};
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign {DeOut, HsOut, VsOut} = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/video_timing_gen.sv
// ----------------------------------------------------------------------------
// video_timing_gen
//   Parametrised raster timing generator. Walks an H/V counter pair over the
//   programmed geometry, requests pixels during active video and emits
//   DE/HS/VS/pixel aligned to data that returns REQ_LAT-1 cycles after the
//   request. Enable is honoured only on frame boundaries: a stop always
//   finishes the frame in progress.
//
// Ports
//   PixelClk         in   pixel clock
//   RstB             in   asynchronous active-low reset
//   Enable           in   run request
//   VideoDin         in   pixel for the request made REQ_LAT-1 cycles ago
//   VideoReq         out  pixel request (combinational)
//   VideoXPos/YPos   out  active column/line, 0 when no request
//   VideoFrameStart  out  first cycle of each frame (combinational)
//   Running          out  FSM is in RUN or STOP (registered)
//   VideoDE/HS/VS    out  registered enable/syncs, REQ_LAT after counters
//   VideoDout        out  registered pixel, BLANK_COLOR outside active video
// ----------------------------------------------------------------------------
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int   H_SYNC  = 44,
    parameter int   H_BACK  = 148,
    parameter int   H_DISP  = 1920,
    parameter int   H_FRONT = 88,
    parameter int   V_SYNC  = 5,
    parameter int   V_BACK  = 36,
    parameter int   V_DISP  = 1080,
    parameter int   V_FRONT = 4,
    parameter logic HS_POL  = 1'b1,
    parameter logic VS_POL  = 1'b1,
    parameter int   DATA_W  = 24,
    parameter int   REQ_LAT = 1,
    parameter logic [DATA_W-1:0] BLANK_COLOR = '1
) (
    input  logic              PixelClk,
    input  logic              RstB,
    input  logic              Enable,
    input  logic [DATA_W-1:0] VideoDin,
    output logic              VideoReq,
    output logic [11:0]       VideoXPos,
    output logic [11:0]       VideoYPos,
    output logic              VideoFrameStart,
    output logic              Running,
    output logic              VideoDE,
    output logic              VideoHS,
    output logic              VideoVS,
    output logic [DATA_W-1:0] VideoDout
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

    generate
        if (H_TOTAL > 4096) begin : gBadHTotal
            $error("video_timing_gen: H_TOTAL must not exceed 4096");
        end
        if (V_TOTAL > 4096) begin : gBadVTotal
            $error("video_timing_gen: V_TOTAL must not exceed 4096");
        end
        if (REQ_LAT < 1 || REQ_LAT > 8) begin : gBadLat
            $error("video_timing_gen: REQ_LAT must be in 1..8");
        end
    endgenerate

    // Region bounds are compared in 13 bits: an active region that ends on
    // the last column of a 4096-wide line has its end bound at 4096.
    localparam logic [12:0] H_SYNC_END = 13'(H_SYNC);
    localparam logic [12:0] H_ACT_BEG  = 13'(H_SYNC + H_BACK);
    localparam logic [12:0] H_ACT_END  = 13'(H_SYNC + H_BACK + H_DISP);
    localparam logic [12:0] V_SYNC_END = 13'(V_SYNC);
    localparam logic [12:0] V_ACT_BEG  = 13'(V_SYNC + V_BACK);
    localparam logic [12:0] V_ACT_END  = 13'(V_SYNC + V_BACK + V_DISP);
    localparam logic [11:0] H_OFFSET   = 12'(H_SYNC + H_BACK);
    localparam logic [11:0] V_OFFSET   = 12'(V_SYNC + V_BACK);
    localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);

    VtgState     state, stateNext;
    logic [11:0] hCnt, hCntNext;
    logic [11:0] vCnt, vCntNext;
    logic        rasterOn;
    logic        lastPix;
    logic        hActive, vActive;
    logic        rawHs, rawVs;
    logic        dlyDe, dlyHs, dlyVs;

    // ---------------- run control and raster counters ----------------

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, as the hardware does.
    always_ff @(posedge PixelClk or negedge RstB) begin
        if (!RstB) begin
            state   <= IDLE;
            hCnt    <= '0;
            vCnt    <= '0;
            Running <= 1'b0;
        end else begin
            state   <= stateNext;
            hCnt    <= hCntNext;
            vCnt    <= vCntNext;
            Running <= (stateNext != IDLE);
        end
    end

    assign rasterOn = (state != IDLE);
    assign lastPix  = (hCnt == H_LAST) && (vCnt == V_LAST);

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        stateNext = state;
        hCntNext  = '0;
        vCntNext  = '0;

        if (rasterOn) begin
            if (hCnt == H_LAST) begin
                hCntNext = '0;
                vCntNext = (vCnt == V_LAST) ? '0 : vCnt + 12'd1;
            end else begin
                hCntNext = hCnt + 12'd1;
                vCntNext = vCnt;
            end
        end

        unique case (state)
            IDLE: if (Enable) stateNext = RUN;
            RUN:  if (!Enable) stateNext = STOP;
            // The counters wrap to 0 on the last pixel anyway, so dropping
            // to IDLE there leaves them at the restart position.
            STOP: begin
                if (Enable)       stateNext = RUN;
                else if (lastPix) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // ---------------- request side (zero latency) ----------------

    assign hActive = ({1'b0, hCnt} >= H_ACT_BEG) && ({1'b0, hCnt} < H_ACT_END);
    assign vActive = ({1'b0, vCnt} >= V_ACT_BEG) && ({1'b0, vCnt} < V_ACT_END);

    assign VideoReq        = rasterOn && hActive && vActive;
    assign VideoXPos       = VideoReq ? (hCnt - H_OFFSET) : '0;
    assign VideoYPos       = VideoReq ? (vCnt - V_OFFSET) : '0;
    assign VideoFrameStart = rasterOn && (hCnt == '0) && (vCnt == '0);

    // Syncs are converted to line polarity before the delay line so idle
    // stages and reset values already hold the inactive level.
    assign rawHs = (rasterOn && ({1'b0, hCnt} < H_SYNC_END)) ? HS_POL : ~HS_POL;
    assign rawVs = (rasterOn && ({1'b0, vCnt} < V_SYNC_END)) ? VS_POL : ~VS_POL;

    // ---------------- output side (REQ_LAT cycles) ----------------

    generate
        if (REQ_LAT > 1) begin : gDelay
            video_sync_delay #(
                .DEPTH   (REQ_LAT - 1),
                .HS_IDLE (~HS_POL),
                .VS_IDLE (~VS_POL)
            ) uSyncDelay (
                .PixelClk (PixelClk),
                .RstB     (RstB),
                .DeIn     (VideoReq),
                .HsIn     (rawHs),
                .VsIn     (rawVs),
                .DeOut    (dlyDe),
                .HsOut    (dlyHs),
                .VsOut    (dlyVs)
            );
        end else begin : gNoDelay
            assign dlyDe = VideoReq;
            assign dlyHs = rawHs;
            assign dlyVs = rawVs;
        end
    endgenerate

    always_ff @(posedge PixelClk or negedge RstB) begin
        if (!RstB) begin
            VideoDE   <= 1'b0;
            VideoHS   <= ~HS_POL;
            VideoVS   <= ~VS_POL;
            VideoDout <= BLANK_COLOR;
        end else begin
            VideoDE   <= dlyDe;
            VideoHS   <= dlyHs;
            VideoVS   <= dlyVs;
            VideoDout <= dlyDe ? VideoDin : BLANK_COLOR;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_video_timing_gen
//   Three generators share clock, reset and Enable on a 14x7 raster:
//     dut1 : REQ_LAT=1, positive syncs
//     dut4 : REQ_LAT=4, positive syncs, data returned 3 cycles after request
//     dutN : REQ_LAT=1, negative syncs
//   Expected values come from a closed-form raster model indexed by cycle
//   number relative to the first RUN cycle.
// ----------------------------------------------------------------------------
module tb_video_timing_gen;
    import video_timing_pkg::*;

    localparam int HT    = 14;        // 2+2+8+2
    localparam int VT    = 7;         // 1+1+4+1
    localparam int FT    = HT * VT;   // 98 cycles per frame
    localparam int DW    = 24;
    localparam int H_BEG = 4;
    localparam int H_END = 12;
    localparam int V_BEG = 2;
    localparam int V_END = 6;

    logic PixelClk = 1'b0;
    logic RstB     = 1'b0;
    logic Enable   = 1'b0;

    always #5 PixelClk = ~PixelClk;

    logic          req1, fs1, run1, de1, hs1, vs1;
    logic [11:0]   x1, y1;
    logic [DW-1:0] din1, dout1;
    logic          req4, fs4, run4, de4, hs4, vs4;
    logic [11:0]   x4, y4;
    logic [DW-1:0] din4, dout4;
    logic          reqN, fsN, runN, deN, hsN, vsN;
    logic [11:0]   xN, yN;
    logic [DW-1:0] dinN, doutN;
    logic [DW-1:0] pipe4 [3];

    // Pixel source: the pixel value is its own coordinate.
    assign din1 = req1 ? {y1, x1} : '0;
    assign dinN = reqN ? {yN, xN} : '0;

    // Fetch model for dut4: request at cycle k is answered during k+3.
    always @(posedge PixelClk) begin
        pipe4[0] <= req4 ? {y4, x4} : '0;
        pipe4[1] <= pipe4[0];
        pipe4[2] <= pipe4[1];
    end
    assign din4 = pipe4[2];

    video_timing_gen #(
        .H_SYNC(2), .H_BACK(2), .H_DISP(8), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .DATA_W(DW), .REQ_LAT(1)
    ) dut1 (
        .PixelClk(PixelClk), .RstB(RstB), .Enable(Enable), .VideoDin(din1),
        .VideoReq(req1), .VideoXPos(x1), .VideoYPos(y1), .VideoFrameStart(fs1),
        .Running(run1), .VideoDE(de1), .VideoHS(hs1), .VideoVS(vs1), .VideoDout(dout1)
    );

    video_timing_gen #(
        .H_SYNC(2), .H_BACK(2), .H_DISP(8), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .DATA_W(DW), .REQ_LAT(4)
    ) dut4 (
        .PixelClk(PixelClk), .RstB(RstB), .Enable(Enable), .VideoDin(din4),
        .VideoReq(req4), .VideoXPos(x4), .VideoYPos(y4), .VideoFrameStart(fs4),
        .Running(run4), .VideoDE(de4), .VideoHS(hs4), .VideoVS(vs4), .VideoDout(dout4)
    );

    video_timing_gen #(
        .H_SYNC(2), .H_BACK(2), .H_DISP(8), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .DATA_W(DW), .REQ_LAT(1)
    ) dutN (
        .PixelClk(PixelClk), .RstB(RstB), .Enable(Enable), .VideoDin(dinN),
        .VideoReq(reqN), .VideoXPos(xN), .VideoYPos(yN), .VideoFrameStart(fsN),
        .Running(runN), .VideoDE(deN), .VideoHS(hsN), .VideoVS(vsN), .VideoDout(doutN)
    );

    int compared   = 0;
    int mismatched = 0;
    int cyc        = -1000;  // cycle index; 0 = first RUN cycle
    int endC       = 0;      // first cycle back in IDLE after the run

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    // ---------------- raster model ----------------
    function automatic bit inRun(int k);
        return (k >= 0) && (k < endC);
    endfunction

    function automatic bit rawDe(int k);
        return inRun(k) && ((k % HT) >= H_BEG) && ((k % HT) < H_END)
                        && (((k / HT) % VT) >= V_BEG) && (((k / HT) % VT) < V_END);
    endfunction

    function automatic bit rawHs(int k);
        return inRun(k) && ((k % HT) < 2);
    endfunction

    function automatic bit rawVs(int k);
        return inRun(k) && (((k / HT) % VT) < 1);
    endfunction

    function automatic logic [31:0] expX(int k);
        return rawDe(k) ? 32'((k % HT) - H_BEG) : 32'd0;
    endfunction

    function automatic logic [31:0] expY(int k);
        return rawDe(k) ? 32'(((k / HT) % VT) - V_BEG) : 32'd0;
    endfunction

    function automatic logic [31:0] expDout(int k);
        return rawDe(k) ? {8'h00, expY(k)[11:0], expX(k)[11:0]} : 32'h00FF_FFFF;
    endfunction

    // One clock, then compare every DUT output against the model.
    task automatic stepCycle();
        @(posedge PixelClk);
        @(negedge PixelClk);
        cyc++;
        check("req1",  req1, rawDe(cyc));
        check("xpos1", x1,   expX(cyc));
        check("ypos1", y1,   expY(cyc));
        check("fs1",   fs1,  inRun(cyc) && (cyc % FT == 0));
        check("run1",  run1, inRun(cyc));
        check("de1",   de1,   rawDe(cyc - 1));
        check("hs1",   hs1,   rawHs(cyc - 1));
        check("vs1",   vs1,   rawVs(cyc - 1));
        check("dout1", dout1, expDout(cyc - 1));
        check("de4",   de4,   rawDe(cyc - 4));
        check("hs4",   hs4,   rawHs(cyc - 4));
        check("vs4",   vs4,   rawVs(cyc - 4));
        check("dout4", dout4, expDout(cyc - 4));
        check("hsN",   hsN,  !rawHs(cyc - 1));
        check("vsN",   vsN,  !rawVs(cyc - 1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    int            firstDe1 = -1, firstDe4 = -1, deCount = 0, lineCount = 0;
    int            hsLowN = 0, vsLowN = 0, runFall = -1, reqAfter = 0;
    logic          prevDe1 = 1'b0, prevRun1 = 1'b0;
    logic [DW-1:0] line0 [8];

    initial begin
        // ---- reset, then 50 idle cycles with Enable low ----
        RstB   = 1'b0;
        Enable = 1'b0;
        repeat (3) @(negedge PixelClk);
        RstB = 1'b1;
        repeat (50) stepCycle();
        check("idle_req1",  req1,  1'b0);
        check("idle_hs1",   hs1,   1'b0);
        check("idle_vs1",   vs1,   1'b0);
        check("idle_dout1", dout1, 32'h00FF_FFFF);
        check("idle_run1",  run1,  1'b0);
        check("idle_hsN",   hsN,   1'b1);
        check("idle_vsN",   vsN,   1'b1);

        // ---- run four frames; stop requested in frame 2 (cancelled) and
        //      again in frame 3 at VCnt=3, so the run ends after 4*98 ----
        endC   = 4 * FT;
        cyc    = -1;
        Enable = 1'b1;
        while (cyc < endC + 10) begin
            stepCycle();
            if (cyc >= 0 && cyc < FT) begin
                if (de1 && firstDe1 < 0) firstDe1 = cyc;
                if (de1 && deCount < 8) line0[deCount] = dout1;
                if (de1) deCount++;
                if (de1 && !prevDe1) lineCount++;
            end
            if (cyc >= 0 && de4 && firstDe4 < 0) firstDe4 = cyc;
            if (cyc >= FT && cyc < 2 * FT) begin
                if (!hsN) hsLowN++;
                if (!vsN) vsLowN++;
            end
            if (prevRun1 && !run1) runFall = cyc;
            if (cyc >= endC && req1) reqAfter++;
            prevDe1  = de1;
            prevRun1 = run1;
            if (cyc == 2 * FT + 3 * HT) Enable = 1'b0;
            if (cyc == 2 * FT + 4 * HT) Enable = 1'b1;
            if (cyc == 3 * FT + 3 * HT) Enable = 1'b0;
        end
        check("first_de_lat1", firstDe1, 33);
        check("first_de_lat4", firstDe4, 36);
        check("de_per_frame",  deCount,  32);
        check("de_lines",      lineCount, 4);
        for (int i = 0; i < 8; i++) check("line0_dout", line0[i], i);
        check("hsN_low_per_frame", hsLowN, 14);
        check("vsN_low_per_frame", vsLowN, 14);
        check("running_fall",      runFall, 4 * FT);
        check("req_after_stop",    reqAfter, 0);

        // ---- restart, then async reset at HCnt=5, VCnt=4 ----
        endC   = 1_000_000;
        cyc    = -1;
        Enable = 1'b1;
        while (cyc < 4 * HT + 5) stepCycle();
        check("pre_rst_de1",   de1,   1'b1);
        check("pre_rst_dout1", dout1, 32'h0000_2000);
        #2 RstB = 1'b0;
        #1;
        check("rst_de1",   de1,   1'b0);
        check("rst_hs1",   hs1,   1'b0);
        check("rst_vs1",   vs1,   1'b0);
        check("rst_dout1", dout1, 32'h00FF_FFFF);
        check("rst_run1",  run1,  1'b0);
        check("rst_req1",  req1,  1'b0);
        check("rst_fs1",   fs1,   1'b0);
        check("rst_hcnt",  dut1.hCnt, 12'd0);
        check("rst_vcnt",  dut1.vCnt, 12'd0);
        check("rst_state", dut1.state, IDLE);
        check("rst_de4",   de4,   1'b0);
        check("rst_hsN",   hsN,   1'b1);
        check("rst_vsN",   vsN,   1'b1);
        Enable = 1'b0;
        repeat (2) @(negedge PixelClk);
        RstB = 1'b1;
        endC = 0;
        cyc  = -1000;
        repeat (20) stepCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
